// File: rtl/uc_pkg.sv
// unidad_control shared types: sequencer opcodes, FSM states,
// control-word field positions and datapath flag indices.
package uc_pkg;

  typedef enum logic [2:0] {
    NEXT = 3'd0,
    JUMP = 3'd1,
    BRZ  = 3'd2,
    BRN  = 3'd3,
    BRC  = 3'd4,
    BRV  = 3'd5,
    BRNZ = 3'd6,
    HALT = 3'd7
  } seq_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] CTRL_NOP = 16'h0000;

  localparam int CW_A_LSB   = 13;
  localparam int CW_B_LSB   = 10;
  localparam int CW_D_LSB   = 7;
  localparam int CW_ALU_LSB = 3;
  localparam int CW_SH_LSB  = 0;

  localparam int FL_V = 3;
  localparam int FL_N = 2;
  localparam int FL_Z = 1;
  localparam int FL_C = 0;

endpackage

// File: rtl/uc_store.sv
// Writable microcode store: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module uc_store #(
  parameter int AW = 5,
  parameter int W  = 19 + AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/unidad_control.sv
// Microprogrammed sequencer: FSM, microaddress and branch logic.
// Optional watchdog built when UC_WATCHDOG_EN is defined.
module unidad_control
  import uc_pkg::*;
#(
  parameter int AW         = 5,
  parameter int START_ADDR = 0,
  parameter int MAX_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           load_en,
  input  logic [AW-1:0]  load_addr,
  input  logic [18+AW:0] load_data,
  input  logic [3:0]     stateBits,
  output logic [15:0]    ctrl_word,
  output logic [AW-1:0]  upc,
  output logic           busy,
  output logic           done,
  output logic           timeout
);

  state_t          state;
  logic [AW-1:0]   upc_q;
  logic [AW-1:0]   nxt;
  logic [18+AW:0]  word;
  seq_op_t         op;
  logic [AW-1:0]   na;
  logic            take;
  logic            we;
  logic            wd_hit;

  assign we = load_en & (state != RUN);

  uc_store #(.AW(AW), .W(19 + AW)) u_store (
    .clk   (clk),
    .we    (we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (upc_q),
    .rdata (word)
  );

  assign op = seq_op_t'(word[18+AW:16+AW]);
  assign na = word[15+AW:16];

  // flags are the datapath's registered result of the previous microword
  always_comb begin
    take = 1'b0;
    unique case (op)
      NEXT: take = 1'b0;
      JUMP: take = 1'b1;
      BRZ:  take = stateBits[FL_Z];
      BRN:  take = stateBits[FL_N];
      BRC:  take = stateBits[FL_C];
      BRV:  take = stateBits[FL_V];
      BRNZ: take = ~stateBits[FL_Z];
      HALT: take = 1'b0;
      default: take = 1'b0;
    endcase
    nxt = take ? na : upc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      upc_q <= AW'(START_ADDR);
    end else begin
      unique case (state)
        RUN: begin
          if (op == HALT || wd_hit) state <= DONE;
          else upc_q <= nxt;
        end
        default: begin
          if (start) begin
            state <= RUN;
            upc_q <= AW'(START_ADDR);
          end
        end
      endcase
    end
  end

`ifdef UC_WATCHDOG_EN
  localparam int CNTW = $clog2(MAX_CYCLES + 1);

  logic [CNTW-1:0] cnt;
  logic            to_q;

  assign wd_hit = (state == RUN) && (op != HALT) &&
                  (cnt == CNTW'(MAX_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        cnt  <= '0;
        to_q <= 1'b0;
      end
    end else if (op != HALT) begin
      cnt <= cnt + 1'b1;
      if (wd_hit) to_q <= 1'b1;
    end
  end

  assign timeout = to_q;
`else
  logic unused_max;

  assign unused_max = ^32'(MAX_CYCLES);
  assign wd_hit     = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign upc       = upc_q;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign ctrl_word = busy ? word[15:0] : CTRL_NOP;

endmodule

// File: tb/tb_unidad_control.sv
// Self-checking bench for unidad_control: per-cycle model compare
// plus directed literal checks.
module tb_unidad_control;

  localparam int MAXC = 8;
`ifdef UC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [23:0] load_data = '0;
  logic [3:0]  stateBits = '0;
  logic [15:0] ctrl_word;
  logic [4:0]  upc;
  logic        busy;
  logic        done;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  unidad_control #(.AW(5), .START_ADDR(0), .MAX_CYCLES(MAXC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .stateBits (stateBits),
    .ctrl_word (ctrl_word),
    .upc       (upc),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // behavioural model: program array plus run/done/pc bookkeeping
  logic [23:0] mmem [32];
  bit m_run = 0;
  bit m_done = 0;
  bit m_to = 0;
  int m_pc = 0;
  int m_cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    int op, na;
    bit tk, was_run;
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_to = 0; m_pc = 0; m_cyc = 0;
    end else begin
      was_run = m_run;
      if (m_run) begin
        op = int'(mmem[m_pc][23:21]);
        na = int'(mmem[m_pc][20:16]);
        case (op)
          1: tk = 1;
          2: tk = stateBits[1];
          3: tk = stateBits[2];
          4: tk = stateBits[0];
          5: tk = stateBits[3];
          6: tk = !stateBits[1];
          default: tk = 0;
        endcase
        if (op == 7) begin
          m_run = 0; m_done = 1;
        end else if (WD && m_cyc + 1 == MAXC) begin
          m_run = 0; m_done = 1; m_to = 1;
        end else begin
          m_pc = tk ? na : (m_pc + 1) % 32;
          m_cyc++;
        end
      end else if (start) begin
        m_run = 1; m_done = 0; m_to = 0; m_pc = 0; m_cyc = 0;
      end
      if (load_en && !was_run) mmem[load_addr] = load_data;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] ec;
    ec = m_run ? mmem[m_pc][15:0] : 16'h0000;
    chk("cyc_ctrl", 32'(ctrl_word), 32'(ec));
    chk("cyc_upc", 32'(upc), 32'(m_pc));
    chk("cyc_busy", 32'(busy), 32'(m_run));
    chk("cyc_done", 32'(done), 32'(m_done));
    chk("cyc_timeout", 32'(timeout), 32'(m_to));
  end

  function automatic logic [23:0] mw(logic [2:0] op, logic [4:0] na,
                                     logic [15:0] c);
    return {op, na, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(logic [4:0] a, logic [23:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic go();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(int bound);
    for (int i = 0; i < bound && !done; i++) tick();
    chk("done_reached", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  logic [2:0] bops [12] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                            3'd5, 3'd5, 3'd6, 3'd6, 3'd1, 3'd0};
  logic [3:0] bfl  [12] = '{4'b0010, 4'b0000, 4'b0100, 4'b1011,
                            4'b0001, 4'b1110, 4'b1000, 4'b0111,
                            4'b0000, 4'b0010, 4'b0000, 4'b1111};
  int         bexp [12] = '{5, 2, 5, 2, 5, 2, 5, 2, 5, 2, 5, 2};

  initial begin
    tick();
    tick();
    chk("rst_ctrl", 32'(ctrl_word), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_upc", 32'(upc), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 32; i++) ld(5'(i), mw(3'd7, 5'd0, 16'h0));

    // straight-line program
    ld(5'd0, mw(3'd0, 5'd0, 16'h2080));
    ld(5'd1, mw(3'd0, 5'd0, 16'h0100));
    ld(5'd2, mw(3'd7, 5'd0, 16'h0000));
    go();
    chk("line_c0", 32'(ctrl_word), 32'h2080);
    chk("line_busy", 32'(busy), 32'd1);
    tick();
    chk("line_c1", 32'(ctrl_word), 32'h0100);
    tick();
    chk("line_c2", 32'(ctrl_word), 32'h0000);
    chk("line_upc2", 32'(upc), 32'd2);
    tick();
    chk("line_done", 32'(done), 32'd1);
    chk("line_nop", 32'(ctrl_word), 32'h0);
    chk("line_upc_hold", 32'(upc), 32'd2);

    // reset mid-run
    ld(5'd0, mw(3'd0, 5'd0, 16'h1111));
    ld(5'd1, mw(3'd0, 5'd0, 16'h2222));
    ld(5'd2, mw(3'd0, 5'd0, 16'h3333));
    ld(5'd3, mw(3'd0, 5'd0, 16'h4444));
    ld(5'd4, mw(3'd7, 5'd0, 16'h5555));
    go();
    tick(); tick(); tick();
    chk("mid_upc3", 32'(upc), 32'd3);
    chk("mid_ctrl3", 32'(ctrl_word), 32'h4444);
    rst_n = 0;
    #1;
    chk("mid_rst_ctrl", 32'(ctrl_word), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_upc", 32'(upc), 32'd0);
    tick();
    rst_n = 1;
    tick();
    go();
    chk("mid_store_kept", 32'(ctrl_word), 32'h1111);
    wait_done(10);

    // conditional branches from word 1
    ld(5'd0, mw(3'd0, 5'd0, 16'h0A58));
    ld(5'd2, mw(3'd7, 5'd0, 16'h0222));
    ld(5'd5, mw(3'd7, 5'd0, 16'h0555));
    for (int i = 0; i < 12; i++) begin
      ld(5'd1, mw(bops[i], 5'd5, 16'h0000));
      go();
      stateBits = bfl[i];
      tick();
      tick();
      chk($sformatf("br%0d_upc", i), 32'(upc), 32'(bexp[i]));
      stateBits = 4'b0000;
      wait_done(5);
    end

    // wrap-around 31 -> 0
    ld(5'd0, mw(3'd2, 5'd31, 16'h00AA));
    ld(5'd31, mw(3'd0, 5'd0, 16'h0031));
    ld(5'd1, mw(3'd7, 5'd0, 16'h0001));
    stateBits = 4'b0010;
    go();
    tick();
    chk("wrap_upc31", 32'(upc), 32'd31);
    chk("wrap_ctrl31", 32'(ctrl_word), 32'h0031);
    stateBits = 4'b0000;
    tick();
    chk("wrap_upc0", 32'(upc), 32'd0);
    wait_done(5);

    // load ignored while running
    ld(5'd0, mw(3'd0, 5'd0, 16'h0A0A));
    ld(5'd1, mw(3'd1, 5'd1, 16'h0B0B));
    go();
    tick();
    load_en = 1; load_addr = 5'd0; load_data = mw(3'd7, 5'd0, 16'hFFFF);
    tick();
    load_en = 0;
    chk("run_load_busy", 32'(busy), 32'd1);
    do_reset();
    go();
    chk("run_load_ignored", 32'(ctrl_word), 32'h0A0A);
    do_reset();

    // load together with start
    load_en = 1; load_addr = 5'd0; load_data = mw(3'd7, 5'd0, 16'hC0DE);
    start = 1;
    tick();
    load_en = 0; start = 0;
    chk("ld_start_ctrl", 32'(ctrl_word), 32'hC0DE);
    chk("ld_start_busy", 32'(busy), 32'd1);
    tick();
    chk("ld_start_done", 32'(done), 32'd1);

    // endless loop: watchdog or none
    ld(5'd0, mw(3'd1, 5'd0, 16'h0770));
    go();
`ifdef UC_WATCHDOG_EN
    repeat (MAXC - 1) tick();
    chk("wd_busy_before", 32'(busy), 32'd1);
    tick();
    chk("wd_done", 32'(done), 32'd1);
    chk("wd_timeout", 32'(timeout), 32'd1);
    go();
    chk("wd_timeout_clr", 32'(timeout), 32'd0);
`else
    repeat (100) tick();
    chk("nowd_busy", 32'(busy), 32'd1);
    chk("nowd_timeout", 32'(timeout), 32'd0);
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
